pri_enc_pend: RTL and testbench

PRI_ENC_PEND -- requirements
Module: pri_enc_pend

---
 rtl/pri_enc_pend.sv | 106 ++++++++++
 tb/tb_pri_enc_pend.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pri_enc_pend.sv
// Pending-request latch with a registered priority grant and hold-until-ack semantics.
// Define PRI_ENC_RR_EN for round-robin selection; otherwise the highest index wins.
module pri_enc_pend #(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] req,
    input  logic         ack,
    output logic [W-1:0] out_idx,
    output logic         out_valid,
    output logic [N-1:0] pend
);

    logic [N-1:0] pend_q, pend_d;
    logic [N-1:0] clr;
    logic [W-1:0] out_idx_q, out_idx_d;
    logic         out_valid_q, out_valid_d;
    logic         accept;
    logic         reselect;
    logic [W-1:0] sel;
    logic         hit;

`ifdef PRI_ENC_RR_EN
    logic [W-1:0] ptr_q, ptr_d;
    int           dist;
    int           best;
`endif

    always_comb begin
        accept = ack && out_valid_q;
        clr    = '0;
        if (accept) clr[out_idx_q] = 1'b1;
        pend_d   = (pend_q & ~clr) | (en ? req : '0);
        reselect = !out_valid_q || accept;
    end

`ifdef PRI_ENC_RR_EN
    // Search order starts just past the last granted index and wraps at N.
    always_comb begin
        ptr_d = accept ? out_idx_q : ptr_q;
        sel   = '0;
        hit   = 1'b0;
        best  = N;
        dist  = 0;
        for (int i = 0; i < N; i++) begin
            if (pend_d[i]) begin
                dist = i - int'(ptr_d) - 1;
                if (dist < 0) dist = dist + N;
                if (dist < best) begin
                    best = dist;
                    sel  = W'(i);
                    hit  = 1'b1;
                end
            end
        end
    end
`else
    always_comb begin
        sel = '0;
        hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (pend_d[i]) begin
                sel = W'(i);
                hit = 1'b1;
            end
        end
    end
`endif

    // Grant is held while unacknowledged; no preemption.
    always_comb begin
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        if (reselect) begin
            out_valid_d = hit;
            if (hit) out_idx_d = sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q      <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef PRI_ENC_RR_EN
    always_ff @(posedge clk) begin
        if (rst) ptr_q <= W'(N - 1);
        else     ptr_q <= ptr_d;
    end
`endif

    assign pend      = pend_q;
    assign out_idx   = out_idx_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_pri_enc_pend.sv
// Scoreboard bench for pri_enc_pend: directed scenarios then random traffic.
module tb_pri_enc_pend;

    localparam int N = 8;
    localparam int W = 3;

    typedef struct {
        logic [N-1:0] pend;
        logic         valid;
        logic [W-1:0] idx;
    } exp_t;

    logic         clk = 1'b1;
    logic         rst, en, ack;
    logic [N-1:0] req;
    logic [W-1:0] out_idx;
    logic         out_valid;
    logic [N-1:0] pend;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference state
    bit [N-1:0] m_pend;
    bit         m_valid;
    int         m_idx;
    int         m_ptr;

    pri_enc_pend #(.N(N)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .ack(ack),
        .out_idx(out_idx), .out_valid(out_valid), .pend(pend)
    );

    always #5 clk = ~clk;

    function automatic int pick(input bit [N-1:0] p, input int ptr);
`ifdef PRI_ENC_RR_EN
        for (int k = 1; k <= N; k++)
            if (p[(ptr + k) % N]) return (ptr + k) % N;
`else
        for (int k = N - 1; k >= 0; k--)
            if (p[k]) return k;
`endif
        return -1;
    endfunction

    task automatic model(input bit r, input bit e,
                         input bit [N-1:0] rq, input bit a);
        bit         accepted;
        bit [N-1:0] np;
        if (r) begin
            m_pend = '0; m_valid = 0; m_idx = 0; m_ptr = N - 1;
        end else begin
            accepted = a && m_valid;
            np = m_pend;
            if (accepted) begin
                np[m_idx] = 1'b0;
                m_ptr = m_idx;
            end
            if (e) np = np | rq;
            if (!m_valid || accepted) begin
                if (np != 0) begin
                    m_valid = 1;
                    m_idx = pick(np, m_ptr);
                end else begin
                    m_valid = 0;
                end
            end
            m_pend = np;
        end
    endtask

    task automatic cyc(input bit r, input bit e,
                       input bit [N-1:0] rq, input bit a);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; req = rq; ack = a;
        model(r, e, rq, a);
        x.pend = m_pend; x.valid = m_valid; x.idx = W'(m_idx);
        q.push_back(x);
    endtask

    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                checks++;
                if (pend !== x.pend) begin
                    failures++;
                    $display("FAIL pend: got %h want %h at %0t", pend, x.pend, $time);
                end
                checks++;
                if (out_valid !== x.valid) begin
                    failures++;
                    $display("FAIL out_valid: got %b want %b at %0t", out_valid, x.valid, $time);
                end
                checks++;
                if (out_idx !== x.idx) begin
                    failures++;
                    $display("FAIL out_idx: got %0d want %0d at %0t", out_idx, x.idx, $time);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; req = '0; ack = 1'b0;
        // Fixed order drain
        cyc(1, 0, 8'h00, 0);
        cyc(0, 1, 8'hA0, 0);
        cyc(0, 0, 8'h00, 1);
        cyc(0, 0, 8'h00, 1);
        cyc(0, 0, 8'h00, 0);
        // Hold against higher-priority arrival
        cyc(1, 0, 8'h00, 0);
        cyc(0, 1, 8'h04, 0);
        cyc(0, 1, 8'h40, 0);
        cyc(0, 0, 8'h00, 0);
        cyc(0, 0, 8'h00, 1);
        // Clear/set collision
        cyc(1, 0, 8'h00, 0);
        cyc(0, 1, 8'h08, 0);
        cyc(0, 1, 8'h08, 1);
        // Enable gate and ack while idle
        cyc(1, 0, 8'h00, 0);
        repeat (4) cyc(0, 0, 8'hFF, 1);
        cyc(0, 1, 8'hFF, 0);
        // Alternation under held requests
        cyc(1, 0, 8'h00, 0);
        repeat (6) cyc(0, 1, 8'h81, 1);
        // Reset mid-operation
        cyc(1, 0, 8'h00, 0);
        cyc(0, 1, 8'hFF, 0);
        cyc(1, 1, 8'hFF, 1);
        cyc(0, 0, 8'h00, 0);
        cyc(0, 1, 8'h01, 1);
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit [N-1:0] rq;
            rq = ($urandom_range(0, 1) == 1) ? N'($urandom & $urandom & $urandom)
                                             : N'($urandom);
            cyc($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
                rq, $urandom_range(0, 2) != 0);
        end
        cyc(0, 0, 8'h00, 0);
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
